// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller slice.
//   state_e     : FSM state encoding (IDLE / PENDING / DRAIN)
//   ADDR_W_DEF  : default PC / target width
//   CNT_W_DEF   : default perf counter width
package pc_redirect_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle of MEM-stage resolution, fetch status and PC-mux/flush controls.
//   slave  : seen by pc_redirect_ctrl (consumes resolution/fetch status,
//            drives PC mux, flushes, squash, status and perf counters)
//   master : seen by the surrounding pipeline (the opposite directions)
interface pc_redirect_ctrl_if
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              mem_valid;
  logic              mem_is_br_jmp;
  logic              mem_taken;
  logic [ADDR_W-1:0] mem_target;
  logic              if_stall;
  logic              fetch_inflight;
  logic              imem_resp_valid;

  logic              pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              resp_squash;
  logic              busy;
  logic              err_sticky;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  redir_cnt;

  modport slave (
    input  mem_valid, mem_is_br_jmp, mem_taken, mem_target,
           if_stall, fetch_inflight, imem_resp_valid,
    output pc_sel, pc_target, flush_ifid, flush_idex, flush_exmem,
           resp_squash, busy, err_sticky, br_cnt, redir_cnt
  );

  modport master (
    output mem_valid, mem_is_br_jmp, mem_taken, mem_target,
           if_stall, fetch_inflight, imem_resp_valid,
    input  pc_sel, pc_target, flush_ifid, flush_idex, flush_exmem,
           resp_squash, busy, err_sticky, br_cnt, redir_cnt
  );
endinterface

// File: rtl/pc_redirect_ctrl_branch_perf_cnt.sv
// Free-running event counter; wraps modulo 2^CNT_W.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event this cycle
//   cnt      : current count
module branch_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer for the pipelined SCPU.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_redirect_ctrl_if.slave -- MEM branch resolution, fetch
//              stall/inflight/response in; PC mux select/target, pipeline
//              flushes, response squash, busy, sticky error, perf counters out.
// A taken branch redirects the PC in the same cycle when fetch can accept it;
// otherwise the target is held in PENDING. If an imem request is outstanding
// at redirect time, DRAIN discards its (now stale) response.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  pc_redirect_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] target_q;
  logic              err_q;

  logic resolve, fire;
  logic br_inc, redir_inc, load_target, err_set, flush;

  assign resolve = bus.mem_valid & bus.mem_is_br_jmp;
  assign fire    = resolve & bus.mem_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_target) target_q <= bus.mem_target;
      if (err_set)     err_q    <= 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    bus.pc_sel      = 1'b0;
    bus.pc_target   = target_q;
    bus.resp_squash = 1'b0;
    flush           = 1'b0;
    br_inc          = 1'b0;
    redir_inc       = 1'b0;
    load_target     = 1'b0;
    err_set         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        br_inc = resolve;
        if (fire) begin
          flush       = 1'b1;
          redir_inc   = 1'b1;
          load_target = 1'b1;
          if (!bus.if_stall) begin
            bus.pc_sel    = 1'b1;
            bus.pc_target = bus.mem_target;
            state_d       = bus.fetch_inflight ? ST_DRAIN : ST_IDLE;
          end else begin
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        // Anything resolving here is younger than the flushed branch.
        err_set    = resolve;
        bus.pc_sel = !bus.if_stall;
        if (!bus.if_stall)
          state_d = bus.fetch_inflight ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        err_set         = resolve;
        bus.resp_squash = bus.imem_resp_valid;
        if (bus.imem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.flush_ifid  = flush;
  assign bus.flush_idex  = flush;
  assign bus.flush_exmem = flush;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.err_sticky  = err_q;

  branch_perf_cnt #(.CNT_W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br_inc),
    .cnt (bus.br_cnt)
  );

  branch_perf_cnt #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redir_inc),
    .cnt (bus.redir_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (CNT_W=4 so counter wrap is reachable).
// Each step drives inputs, pushes the expected outputs to a queue, then pops
// and compares mid-cycle before the next rising edge.
module tb_pc_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef struct {
    string             name;
    logic              pc_sel;
    logic [ADDR_W-1:0] pc_target;
    logic [2:0]        flush;
    logic              resp_squash;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  redir_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t             sb[$];
  int               vectors     = 0;
  int               miscompares = 0;
  logic             exp_err     = 1'b0;
  logic [CNT_W-1:0] exp_br      = '0;
  logic [CNT_W-1:0] exp_redir   = '0;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic bj, input logic tk,
                       input logic [ADDR_W-1:0] tgt, input logic stall,
                       input logic infl, input logic resp);
    bus.mem_valid       = mv;
    bus.mem_is_br_jmp   = bj;
    bus.mem_taken       = tk;
    bus.mem_target      = tgt;
    bus.if_stall        = stall;
    bus.fetch_inflight  = infl;
    bus.imem_resp_valid = resp;
  endtask

  task automatic expect_out(input string name, input logic sel,
                            input logic [ADDR_W-1:0] tgt, input logic [2:0] fl,
                            input logic sq, input logic busy);
    exp_t e;
    e.name = name; e.pc_sel = sel; e.pc_target = tgt; e.flush = fl;
    e.resp_squash = sq; e.busy = busy; e.err = exp_err;
    e.br_cnt = exp_br; e.redir_cnt = exp_redir;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.name, "pc_sel", 32'(bus.pc_sel), 32'(e.pc_sel));
    if (e.pc_sel) cmp(e.name, "pc_target", bus.pc_target, e.pc_target);
    cmp(e.name, "flush", 32'({bus.flush_ifid, bus.flush_idex, bus.flush_exmem}),
        32'(e.flush));
    cmp(e.name, "resp_squash", 32'(bus.resp_squash), 32'(e.resp_squash));
    cmp(e.name, "busy", 32'(bus.busy), 32'(e.busy));
    cmp(e.name, "err_sticky", 32'(bus.err_sticky), 32'(e.err));
    cmp(e.name, "br_cnt", 32'(bus.br_cnt), 32'(e.br_cnt));
    cmp(e.name, "redir_cnt", 32'(bus.redir_cnt), 32'(e.redir_cnt));
  endtask

  // One clock step: drive just after the rising edge, check before the next.
  task automatic step(input string name, input logic mv, input logic bj,
                      input logic tk, input logic [ADDR_W-1:0] tgt,
                      input logic stall, input logic infl, input logic resp,
                      input logic e_sel, input logic [ADDR_W-1:0] e_tgt,
                      input logic [2:0] e_fl, input logic e_sq, input logic e_busy);
    @(posedge clk);
    #1;
    drive(mv, bj, tk, tgt, stall, infl, resp);
    expect_out(name, e_sel, e_tgt, e_fl, e_sq, e_busy);
    #3;
    check_out();
  endtask

  task automatic idle(input string name, input logic e_busy);
    step(name, 0, 0, 0, '0, 0, 0, 0, 0, '0, 3'b000, 0, e_busy);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0);
    #3;
    expect_out("reset", 0, '0, 3'b000, 0, 0);
    check_out();
    cmp("reset", "pc_target", bus.pc_target, '0);
    @(negedge clk);
    rst = 1'b0;

    // 1: taken, no stall -> zero-cycle redirect
    step("t1_fire", 1, 1, 1, 32'h40, 0, 0, 0, 1, 32'h40, 3'b111, 0, 0);
    exp_br++; exp_redir++;
    idle("t1_after", 0);

    // 2: not taken; also a bubble carrying branch bits must be ignored
    step("t2_nt", 1, 1, 0, 32'h80, 0, 0, 0, 0, '0, 3'b000, 0, 0);
    exp_br++;
    step("t2_bubble", 0, 1, 1, 32'h84, 0, 0, 0, 0, '0, 3'b000, 0, 0);
    idle("t2_after", 0);

    // 3: fire while stalled for 3 cycles
    step("t3_fire", 1, 1, 1, 32'h100, 1, 0, 0, 0, '0, 3'b111, 0, 0);
    exp_br++; exp_redir++;
    step("t3_stall1", 0, 0, 0, '0, 1, 0, 0, 0, '0, 3'b000, 0, 1);
    step("t3_stall2", 0, 0, 0, '0, 1, 0, 0, 0, '0, 3'b000, 0, 1);
    step("t3_release", 0, 0, 0, '0, 0, 0, 0, 1, 32'h100, 3'b000, 0, 1);
    idle("t3_after", 0);

    // 4: fire with fetch in flight, response two cycles later
    step("t4_fire", 1, 1, 1, 32'h200, 0, 1, 0, 1, 32'h200, 3'b111, 0, 0);
    exp_br++; exp_redir++;
    step("t4_wait", 0, 0, 0, '0, 0, 1, 0, 0, '0, 3'b000, 0, 1);
    step("t4_resp", 0, 0, 0, '0, 0, 1, 1, 0, '0, 3'b000, 1, 1);
    idle("t4_after", 0);

    // 5: resolve during PENDING is illegal; then reset mid-DRAIN
    step("t5_fire", 1, 1, 1, 32'h300, 1, 0, 0, 0, '0, 3'b111, 0, 0);
    exp_br++; exp_redir++;
    step("t5_illegal", 1, 1, 1, 32'h999, 1, 0, 0, 0, '0, 3'b000, 0, 1);
    exp_err = 1'b1;
    step("t5_release", 0, 0, 0, '0, 0, 1, 0, 1, 32'h300, 3'b000, 0, 1);
    step("t5_drain", 0, 0, 0, '0, 0, 1, 0, 0, '0, 3'b000, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 1, 1);
    exp_err = 1'b0; exp_br = '0; exp_redir = '0;
    expect_out("t5_rst", 0, '0, 3'b000, 0, 0);
    #3;
    check_out();
    @(negedge clk);
    rst = 1'b0;
    step("t5_post_rst", 0, 0, 0, '0, 0, 0, 1, 0, '0, 3'b000, 0, 0);

    // 6: 16 taken fires wrap the 4-bit counters back to 0
    for (int i = 0; i < 16; i++) begin
      step("t6_fire", 1, 1, 1, ADDR_W'(32'h1000 + 4 * i), 0, 0, 0,
           1, ADDR_W'(32'h1000 + 4 * i), 3'b111, 0, 0);
      exp_br++; exp_redir++;
    end
    idle("t6_wrapped", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
